// File: rtl/seq_shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier_if
//   Request/response bundle between the execute-path controller and the
//   iterative shift-and-add multiplier.
//
//   Signals (WIDTH = operand width):
//     start      controller -> mult  request, taken only when busy==0
//     rs         controller -> mult  multiplicand
//     rd         controller -> mult  multiplier
//     is_signed  controller -> mult  two's-complement operands (signed build only)
//     q          mult -> controller  product[WIDTH-1:0]
//     q_hi       mult -> controller  product[2*WIDTH-1:WIDTH]
//     overflow   mult -> controller  product does not fit in WIDTH bits
//     busy       mult -> controller  iteration in progress
//     done       mult -> controller  one-cycle pulse, q/q_hi/overflow valid
//
//   Modports: master = controller side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rd;
    logic             is_signed;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_hi;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, rs, rd, is_signed,
        input  q, q_hi, overflow, busy, done
    );

    modport slave (
        input  start, rs, rd, is_signed,
        output q, q_hi, overflow, busy, done
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
//   Iterative shift-and-add multiplier: one partial product per clock into a
//   2*WIDTH accumulator, so the critical path is a single 2*WIDTH adder.
//   Latency is fixed: busy is high for WIDTH cycles after the accepting edge,
//   then done pulses for one cycle with the full product on q_hi:q.
//
//   Parameters:
//     WIDTH      operand width (>= 2); product is 2*WIDTH bits
//
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset; aborts any operation in flight
//     bus        seq_shift_add_multiplier_if.slave (start/rs/rd/is_signed in,
//                q/q_hi/overflow/busy/done out)
//
//   Build option:
//     MULT_SIGNED_EN  when defined, is_signed=1 multiplies two's-complement
//                     operands (magnitudes through the unsigned datapath, sign
//                     applied on the final edge). When undefined, is_signed
//                     is ignored and no negation logic is built.
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    seq_shift_add_multiplier_if.slave     bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            last;

    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand;     // multiplicand, shifted left once per iteration
    logic [WIDTH-1:0] mplier;   // multiplier, shifted right once per iteration
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nxt;
    logic [PW-1:0]   prod;
    logic            ovf_nxt;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The last iteration and the exit to DONE share one edge: when cnt is
    // WIDTH-1 the edge performs iteration WIDTH and latches the result, so
    // done rises exactly WIDTH edges after the accepting edge.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);

    // -----------------------------------------------------------------------
    // Operand conditioning
    // -----------------------------------------------------------------------
`ifdef MULT_SIGNED_EN
    logic neg_a;
    logic neg_b;
    logic neg;       // result must be negated on the final edge
    logic sgn_op;    // current op is signed: selects the overflow rule

    assign neg_a = bus.is_signed & bus.rs[WIDTH-1];
    assign neg_b = bus.is_signed & bus.rd[WIDTH-1];

    // The most-negative value negates to itself, which read as unsigned is
    // exactly its magnitude 2^(WIDTH-1), so no special case is needed.
    always_comb begin
        mag_a = bus.rs;
        mag_b = bus.rd;
        if (neg_a) mag_a = ~bus.rs + WIDTH'(1);
        if (neg_b) mag_b = ~bus.rd + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg    <= 1'b0;
            sgn_op <= 1'b0;
        end else if (accept) begin
            neg    <= neg_a ^ neg_b;
            sgn_op <= bus.is_signed;
        end
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = bus.is_signed;
    assign mag_a = bus.rs;
    assign mag_b = bus.rd;
`endif

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    // mcand never holds more than WIDTH significant bits shifted by at most
    // WIDTH-1, so the 2*WIDTH accumulator cannot wrap.
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef MULT_SIGNED_EN
    assign prod    = neg ? (~acc_nxt + PW'(1)) : acc_nxt;
    assign ovf_nxt = sgn_op ? (prod[PW-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                            : (prod[PW-1:WIDTH] != '0);
`else
    assign prod    = acc_nxt;
    assign ovf_nxt = (prod[PW-1:WIDTH] != '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            bus.q        <= '0;
            bus.q_hi     <= '0;
            bus.overflow <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
        end else if (state == S_RUN) begin
            cnt    <= cnt + CW'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
            // Result registers move only on the edge that raises done.
            if (last) begin
                bus.q        <= prod[WIDTH-1:0];
                bus.q_hi     <= prod[PW-1:WIDTH];
                bus.overflow <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
//   Drives a WIDTH=16 and a WIDTH=8 multiplier. Expected products come from
//   plain integer multiplication of the operands (sign-interpreted when the
//   signed build is enabled and is_signed=1).
// ---------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_shift_add_multiplier_if #(.WIDTH(16)) bus16 ();
    seq_shift_add_multiplier_if #(.WIDTH(8))  bus8  ();

    seq_shift_add_multiplier #(.WIDTH(16)) u_mul16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) u_mul8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit eff_signed(input bit s);
`ifdef MULT_SIGNED_EN
        return s;
`else
        return 1'b0;
`endif
    endfunction

    function automatic longint ref_val(input int w, input logic [31:0] a, input bit s);
        longint x;
        x = longint'(a);
        if (eff_signed(s) && a[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input bit s);
        longint p;
        p = ref_val(w, a, s) * ref_val(w, b, s);
        return 64'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic logic ref_ovf(input int w, input logic [31:0] a,
                                     input logic [31:0] b, input bit s);
        longint p;
        p = ref_val(w, a, s) * ref_val(w, b, s);
        if (eff_signed(s))
            return (p < -(longint'(1) << (w - 1))) || (p >= (longint'(1) << (w - 1)));
        return p >= (longint'(1) << w);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input bit s);
        bus16.rs        = a;
        bus16.rd        = b;
        bus16.is_signed = s;
        bus16.start     = 1'b1;
        @(posedge clk); #1;
        bus16.start     = 1'b0;
    endtask

    // Called at #1 after the accepting edge. poke >= 0 re-pulses start with
    // fresh operands at that RUN cycle and leaves the operands scrambled.
    task automatic wait_done16(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input bit s, input int poke, input bit pulse_chk);
        int          cyc;
        int          bc;
        logic [63:0] e;
        logic        eo;
        e   = ref_prod(16, 32'(a), 32'(b), s);
        eo  = ref_ovf(16, 32'(a), 32'(b), s);
        cyc = 0;
        bc  = bus16.busy ? 1 : 0;
        while (!bus16.done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus16.busy) bc++;
            if (cyc == poke) begin
                bus16.start = 1'b1;
                bus16.rs    = 16'($urandom);
                bus16.rd    = 16'($urandom);
            end else begin
                bus16.start = 1'b0;
            end
        end
        bus16.start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd16);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd16);
        check({tag, "_q"}, 64'(bus16.q), 64'(e[15:0]));
        check({tag, "_q_hi"}, 64'(bus16.q_hi), 64'(e[31:16]));
        check({tag, "_ovf"}, 64'(bus16.overflow), 64'(eo));
        if (pulse_chk) begin
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, 64'(bus16.done), 64'd0);
            check({tag, "_q_hold"}, 64'({bus16.q_hi, bus16.q}), 64'(e[31:0]));
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input bit s, input int poke);
        start16(a, b, s);
        wait_done16(tag, a, b, s, poke, 1'b1);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b);
        int          cyc;
        int          bc;
        logic [63:0] e;
        e = ref_prod(8, 32'(a), 32'(b), 1'b0);
        bus8.rs    = a;
        bus8.rd    = b;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        cyc = 0;
        bc  = bus8.busy ? 1 : 0;
        while (!bus8.done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus8.busy) bc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd8);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd8);
        check({tag, "_q"}, 64'(bus8.q), 64'(e[7:0]));
        check({tag, "_q_hi"}, 64'(bus8.q_hi), 64'(e[15:8]));
        check({tag, "_ovf"}, 64'(bus8.overflow), 64'(ref_ovf(8, 32'(a), 32'(b), 1'b0)));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus8.done), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int          dn;
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus16.start     = 1'b0;
        bus16.rs        = '0;
        bus16.rd        = '0;
        bus16.is_signed = 1'b0;
        bus8.start      = 1'b0;
        bus8.rs         = '0;
        bus8.rd         = '0;
        bus8.is_signed  = 1'b0;

        // Reset state
        #12;
        check("rst_outputs16", 64'({bus16.q_hi, bus16.q, bus16.overflow, bus16.busy, bus16.done}), 64'd0);
        check("rst_outputs8", 64'({bus8.q_hi, bus8.q, bus8.overflow, bus8.busy, bus8.done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic cases
        op16("mul_3x5", 16'd3, 16'd5, 1'b0, -1);
        op16("mul_ffff_u", 16'hFFFF, 16'hFFFF, 1'b0, -1);
        op16("mul_zero", 16'h0000, 16'h1234, 1'b0, -1);
        op16("mul_zero_b", 16'hBEEF, 16'h0000, 1'b1, -1);

        // Signed-mode vectors (unsigned results when the signed build is off)
        op16("s_ffff", 16'hFFFF, 16'hFFFF, 1'b1, -1);
        op16("s_fffd_4", 16'hFFFD, 16'h0004, 1'b1, -1);
        op16("s_8000_8000", 16'h8000, 16'h8000, 1'b1, -1);
        op16("s_8000_1", 16'h8000, 16'h0001, 1'b1, -1);

        // start while busy plus operand changes during RUN are ignored
        op16("poke_run", 16'h1357, 16'h2468, 1'b0, 5);

        // Back-to-back: start during the DONE cycle
        start16(16'h00FF, 16'h0101, 1'b0);
        wait_done16("b2b_first", 16'h00FF, 16'h0101, 1'b0, -1, 1'b0);
        start16(16'hA5A5, 16'h0003, 1'b0);
        check("b2b_busy_after_accept", 64'(bus16.busy), 64'd1);
        check("b2b_done_single", 64'(bus16.done), 64'd0);
        wait_done16("b2b_second", 16'hA5A5, 16'h0003, 1'b0, -1, 1'b1);

        // Reset in the middle of RUN
        start16(16'h4321, 16'h0777, 1'b0);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({bus16.q_hi, bus16.q, bus16.overflow, bus16.busy, bus16.done}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus16.done) dn++;
        end
        check("midrst_no_done", 64'(dn), 64'd0);
        op16("post_rst", 16'h4321, 16'h0777, 1'b0, -1);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 6 == 0) a = 16'h8000;
            op16("rand16", a, b, 1'($urandom), (i % 4 == 0) ? 3 + i % 10 : -1);
        end

        // WIDTH=8 instance
        op8("w8_c8x0a", 8'hC8, 8'h0A);
        op8("w8_ffxff", 8'hFF, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            op8("rand8", 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
